spi_master: RTL

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI master with programmable CPOL/CPHA latched per frame and a registered SCK/MOSI/CS.
// Bit order: MSB first by default; define SPI_MASTER_LSB_FIRST_EN for LSB-first frames.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_MISO,
  output logic              o_SCK,
  output logic              o_MOSI,
  output logic              o_CS,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rx_data,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int HW = $clog2(CLK_DIV);
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);

  state_t            state;
  logic [HW-1:0]     half_cnt;
  logic [EW-1:0]     edge_cnt;
  logic              cpol_q;
  logic              cpha_q;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;

`ifdef SPI_MASTER_LSB_FIRST_EN
  function automatic logic first_bit(input logic [DATA_W-1:0] d);
    return d[0];
  endfunction
  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] d);
    return d >> 1;
  endfunction
  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] d, input logic b);
    return {b, d[DATA_W-1:1]};
  endfunction
`else
  function automatic logic first_bit(input logic [DATA_W-1:0] d);
    return d[DATA_W-1];
  endfunction
  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] d);
    return d << 1;
  endfunction
  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] d, input logic b);
    return {d[DATA_W-2:0], b};
  endfunction
`endif

  // Even edge_cnt values are leading edges (SCK leaves its idle level).
  logic tick, leading, last_edge, shift_ev, sample_ev;
  assign tick      = (half_cnt == HALF_LAST);
  assign leading   = ~edge_cnt[0];
  assign last_edge = (edge_cnt == EDGE_LAST);
  assign shift_ev  = cpha_q ? leading : (~leading & ~last_edge);
  assign sample_ev = cpha_q ? ~leading : leading;

  assign dbg_state = state;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      half_cnt  <= '0;
      edge_cnt  <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      o_SCK     <= 1'b0;
      o_MOSI    <= 1'b0;
      o_CS      <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_rx_data <= '0;
    end else begin
      o_done <= 1'b0;
      if (state != IDLE) half_cnt <= tick ? '0 : half_cnt + 1'b1;
      case (state)
        IDLE: begin
          o_SCK    <= i_cpol;
          o_MOSI   <= 1'b0;
          o_CS     <= 1'b1;
          half_cnt <= '0;
          edge_cnt <= '0;
          if (i_start) begin
            cpol_q <= i_cpol;
            cpha_q <= i_cpha;
            rx_sr  <= '0;
            o_CS   <= 1'b0;
            o_busy <= 1'b1;
            state  <= SETUP;
            // CPHA=0 must present the first bit before the first (sampling) edge.
            if (i_cpha) begin
              tx_sr <= i_tx_data;
            end else begin
              o_MOSI <= first_bit(i_tx_data);
              tx_sr  <= tx_shift(i_tx_data);
            end
          end
        end
        SETUP: begin
          if (tick) state <= XFER;
        end
        XFER: begin
          if (tick) begin
            o_SCK    <= ~o_SCK;
            edge_cnt <= last_edge ? '0 : edge_cnt + 1'b1;
            if (shift_ev) begin
              o_MOSI <= first_bit(tx_sr);
              tx_sr  <= tx_shift(tx_sr);
            end
            if (sample_ev) rx_sr <= rx_shift(rx_sr, i_MISO);
            if (last_edge) state <= HOLD;
          end
        end
        HOLD: begin
          o_SCK <= cpol_q;
          if (tick) begin
            state     <= IDLE;
            o_CS      <= 1'b1;
            o_MOSI    <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_rx_data <= rx_sr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
